// File: rtl/cpu_pkg.sv
// ============================================================
// Package : cpu_pkg
// Desc    : Shared CPU constants, ABI register indices, ALU selects
// Revision: 1.0
// ============================================================
`default_nettype none

package cpu_pkg;

    localparam int XLEN     = 32;
    localparam int AW       = 5;
    localparam int NUM_REGS = 2 ** AW;

    localparam logic [AW-1:0] ZERO = 5'd0;
    localparam logic [AW-1:0] RA   = 5'd1;
    localparam logic [AW-1:0] SP   = 5'd2;

    // Decode and ALU both key off these encodings
    typedef enum logic [3:0] {
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd3,
        ALU_AND = 4'd4,
        ALU_OR  = 4'd5,
        ALU_XOR = 4'd6,
        ALU_SLT = 4'd8
    } alu_sel_e;

endpackage : cpu_pkg

`default_nettype wire

// File: rtl/reg_file_if.sv
// ============================================================
// Interface : reg_file_if
// Desc      : Read, write and debug signals of the register file
// Revision  : 1.0
// ============================================================
`default_nettype none

interface reg_file_if #(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int AW   = cpu_pkg::AW
);

    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] wr_data;
    logic [AW-1:0]   dbg_addr;
    logic [XLEN-1:0] dbg_data;
    logic [15:0]     wr_count;

    modport master (
        output rs1_addr, rs2_addr, we, rd_addr, wr_data, dbg_addr,
        input  rs1_data, rs2_data, dbg_data, wr_count
    );

    modport slave (
        input  rs1_addr, rs2_addr, we, rd_addr, wr_data, dbg_addr,
        output rs1_data, rs2_data, dbg_data, wr_count
    );

endinterface : reg_file_if

`default_nettype wire

// File: rtl/reg_read_port.sv
// ============================================================
// Module  : reg_read_port
// Desc    : One combinational read port with x0 forcing and optional bypass
// Revision: 1.0
// ============================================================
`default_nettype none

module reg_read_port #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  wire logic [AW-1:0]                  addr,
    input  wire logic [(2**AW)-1:0][XLEN-1:0]   regs,
    input  wire logic                           we,
    input  wire logic [AW-1:0]                  rd_addr,
    input  wire logic [XLEN-1:0]                wr_data,
    output logic      [XLEN-1:0]                data
);

    logic w_hit;

    // addr != 0 already implies rd_addr != 0 on a hit
    assign w_hit = (BYPASS != 0) && we && (rd_addr == addr);

    always_comb begin
        data = '0;
        if (addr != '0) begin
            if (w_hit) begin
                data = wr_data;
            end else begin
                data = regs[addr];
            end
        end
    end

endmodule : reg_read_port

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================
// Module  : reg_file
// Desc    : 32x32 register file, two ALU read ports, one write port, debug port
// Revision: 1.0
// ============================================================
`default_nettype none

module reg_file #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    reg_file_if.slave  bus
);

    import cpu_pkg::*;

    localparam int C_NUM = 2 ** AW;

    logic [C_NUM-1:0][XLEN-1:0] r_regs;
    logic [15:0]                r_wr_count;
    logic                       w_commit;
    logic                       w_we_live;

    assign w_commit = bus.we && (bus.rd_addr != ZERO);

    // Bypass must not leak wr_data while the array is held in reset
    assign w_we_live = bus.we && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs     <= '0;
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[bus.rd_addr] <= bus.wr_data;
            if (r_wr_count != 16'hFFFF) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    reg_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs1 (
        .addr    (bus.rs1_addr),
        .regs    (r_regs),
        .we      (w_we_live),
        .rd_addr (bus.rd_addr),
        .wr_data (bus.wr_data),
        .data    (bus.rs1_data)
    );

    reg_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rs2 (
        .addr    (bus.rs2_addr),
        .regs    (r_regs),
        .we      (w_we_live),
        .rd_addr (bus.rd_addr),
        .wr_data (bus.wr_data),
        .data    (bus.rs2_data)
    );

    reg_read_port #(.XLEN(XLEN), .AW(AW), .BYPASS(0)) u_dbg (
        .addr    (bus.dbg_addr),
        .regs    (r_regs),
        .we      (1'b0),
        .rd_addr (bus.rd_addr),
        .wr_data (bus.wr_data),
        .data    (bus.dbg_data)
    );

    assign bus.wr_count = r_wr_count;

endmodule : reg_file

`default_nettype wire

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry, 32-bit general-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU: its two read ports drive the ALU op1/op2 operands (op2 through the immediate mux).
- Write-back (ALU result or load data) returns through the single write port.
- Register 0 is hardwired to zero. A third read-only debug port lets the bench/tooling inspect architectural state.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- AW, 5, register address width; entry count is 2**AW.
- BYPASS, 1, 1 = a read of the register being written this cycle returns wr_data (write-through); 0 = the read returns the old value until the next edge.

Ports:
- clk  in  1  system clock; all writes occur on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rs1_addr  in  AW  read port 1 address (to ALU op1).
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_addr  in  AW  read port 2 address (to ALU op2 mux).
- rs2_data  out  XLEN  read port 2 data, combinational.
- we  in  1  write enable.
- rd_addr  in  AW  write address.
- wr_data  in  XLEN  write data (from write-back mux).
- dbg_addr  in  AW  debug read address.
- dbg_data  out  XLEN  debug read data, combinational, never bypassed.
- wr_count  out  16  count of committed writes to nonzero registers, saturating.

Behaviour:
- Reset:
  - rst_n low forces every register entry to 0 and wr_count to 0 immediately, without waiting for a clock edge.
  - While rst_n is low, all data outputs read 0.
  - Writes are ignored while rst_n is low.
  - The first write takes effect on the first rising edge at which rst_n is high.
- Write:
  - On a rising clk edge with we=1 and rd_addr!=0, entry[rd_addr] <= wr_data, and wr_count increments by 1, saturating at 16'hFFFF.
  - we=1 with rd_addr=0 is a no-op: entry 0 is unchanged and wr_count does not increment.
  - we=0 is a no-op.
- Read:
  - rsN_data = 0 when rsN_addr=0; otherwise entry[rsN_addr].
  - Reads are purely combinational, with zero-cycle latency.
- Bypass (BYPASS=1):
  - If we=1, rd_addr!=0 and rsN_addr==rd_addr, then rsN_data = wr_data in the same cycle.
  - Ports rs1 and rs2 bypass independently; both may hit simultaneously.
- No bypass (BYPASS=0): reads in the write cycle return the pre-edge value. The new value is visible after the edge.
- Same address on both read ports: both ports return identical data.
- dbg_data = entry[dbg_addr], or 0 for address 0. It ignores the bypass path.
- Reset asserted mid-cycle while we=1: the pending write is lost and all entries read 0.
- No X propagation: entries are always initialised by reset, and outputs are never X after the first reset.

Decomposition:
- Shared package cpu_pkg holds:
  - XLEN=32, AW=5 and NUM_REGS=32 constants.
  - Named ABI register indices: ZERO=0, RA=1, SP=2.
  - The ALU select encodings (ADD=2, SUB=3, AND=4, OR=5, XOR=6, SLT=8), so decode logic and the ALU share one definition.
- One natural sub-module: reg_read_port (address in, storage array view and write-port signals in, data out). It implements the x0 zero-forcing and optional bypass, and is instantiated twice for rs1/rs2.
- The debug port reuses reg_read_port with bypass tied off.

Test Plan:
- Reset, then read all 32 addresses on rs1, rs2 and dbg -> every value is 0 and wr_count=0.
- Write 32'hDEADBEEF to r5, then read r5 on rs1 and rs2 next cycle -> both return 32'hDEADBEEF; wr_count=1.
- we=1, rd_addr=0, wr_data=32'hFFFFFFFF, then read r0 -> 0; wr_count unchanged.
- BYPASS=1: write 32'h12345678 to r7 while rs1_addr=rs2_addr=7 and r7 holds 32'h1 -> both ports show 32'h12345678 in the same cycle, and dbg_data (addr 7) shows 32'h1 until the edge.
- BYPASS=0: same stimulus -> rs1_data=rs2_data=32'h1 before the edge and 32'h12345678 after.
- Write r3=32'hA5A5A5A5, then assert rst_n low asynchronously mid-cycle with we=1, rd_addr=3 -> r3 reads 0 immediately and wr_count=0. After release, a write of 32'h00000042 lands on the next edge and wr_count=1.
